// File: rtl/fmdll_lock_detect.sv
// FMDLL lock detector: watches PTC delay-code updates and reports lock,
// loss of lock and update-watchdog expiry in the clk_ext domain.
module fmdll_lock_detect #(
    parameter int TOL         = 2,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_CNT  = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk_ext,
    input  logic       rst_n,
    input  logic [1:0] M,
    input  logic [3:0] N,
    input  logic [1:0] Sel,
    input  logic [9:0] Q,
    input  logic       code_upd,
    output logic       locked,
    output logic [9:0] q_locked,
    output logic       lock_lost,
    output logic       timeout,
    output logic [7:0] lost_cnt
);

    localparam int WDW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [9:0]     q_prev, q_prev_nx;
    logic [9:0]     q_lock_nx;
    logic [7:0]     stable_cnt, stable_nx;
    logic [3:0]     miss_cnt, miss_nx;
    logic [WDW-1:0] wd_cnt, wd_nx;
    logic [1:0]     m_r;
    logic [3:0]     n_r;
    logic [10:0]    delta;
    logic           stable, hold, mn_chg, wd_exp;
    logic           lost_ev, to_ev;

    always_ff @(posedge clk_ext) begin
        if (!rst_n) begin
            state      <= IDLE;
            q_prev     <= '0;
            q_locked   <= '0;
            stable_cnt <= '0;
            miss_cnt   <= '0;
            wd_cnt     <= '0;
            lock_lost  <= 1'b0;
            timeout    <= 1'b0;
            lost_cnt   <= '0;
            m_r        <= M;
            n_r        <= N;
        end else begin
            state      <= state_nx;
            q_prev     <= q_prev_nx;
            q_locked   <= q_lock_nx;
            stable_cnt <= stable_nx;
            miss_cnt   <= miss_nx;
            wd_cnt     <= wd_nx;
            lock_lost  <= lost_ev;
            timeout    <= to_ev;
            m_r        <= M;
            n_r        <= N;
            if (lost_ev && lost_cnt != 8'hFF)
                lost_cnt <= lost_cnt + 1'b1;
        end
    end

    always_comb begin
        delta = (Q >= q_prev) ? ({1'b0, Q} - {1'b0, q_prev})
                              : ({1'b0, q_prev} - {1'b0, Q});
        stable = (delta <= 11'(TOL));
        hold   = (Sel == 2'b10);
        mn_chg = (M != m_r) || (N != n_r);
        wd_exp = (state != IDLE) && !code_upd
              && (wd_cnt == WDW'(TIMEOUT_CYC - 1));
    end

    always_comb begin
        state_nx  = state;
        q_prev_nx = q_prev;
        q_lock_nx = q_locked;
        stable_nx = stable_cnt;
        miss_nx   = miss_cnt;
        wd_nx     = (state == IDLE || code_upd) ? '0 : wd_cnt + 1'b1;
        lost_ev   = 1'b0;
        to_ev     = 1'b0;
        if (hold) begin
            state_nx  = IDLE;
            stable_nx = '0;
            miss_nx   = '0;
            wd_nx     = '0;
            lost_ev   = (state == LOCKED);
        end else if (mn_chg) begin
            // New M/N restarts acquisition; the strobe on this edge is dropped
            if (state != IDLE)
                state_nx = ACQ;
            stable_nx = '0;
            miss_nx   = '0;
            wd_nx     = '0;
            lost_ev   = (state == LOCKED);
        end else if (wd_exp) begin
            state_nx  = IDLE;
            stable_nx = '0;
            miss_nx   = '0;
            wd_nx     = '0;
            to_ev     = 1'b1;
            lost_ev   = (state == LOCKED);
        end else if (code_upd) begin
            q_prev_nx = Q;
            unique case (state)
                IDLE: begin
                    state_nx  = ACQ;
                    stable_nx = '0;
                end
                ACQ: begin
                    if (!stable) begin
                        stable_nx = '0;
                    end else if (stable_cnt == 8'(LOCK_CNT - 1)) begin
                        state_nx  = LOCKED;
                        q_lock_nx = Q;
                        stable_nx = '0;
                        miss_nx   = '0;
                    end else begin
                        stable_nx = stable_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (stable) begin
                        miss_nx = '0;
                    end else if (miss_cnt == 4'(UNLOCK_CNT - 1)) begin
                        state_nx  = ACQ;
                        stable_nx = '0;
                        miss_nx   = '0;
                        lost_ev   = 1'b1;
                    end else begin
                        miss_nx = miss_cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

endmodule

// File: tb/tb_fmdll_lock_detect.sv
// Testbench for fmdll_lock_detect: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the lock rules.
module tb_fmdll_lock_detect;

    localparam int TOL  = 2;
    localparam int LOCK = 8;
    localparam int UNL  = 3;
    localparam int TO   = 1024;

    logic       clk_ext = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] M = 2'd1;
    logic [3:0] N = 4'd4;
    logic [1:0] Sel = 2'b01;
    logic [9:0] Q = '0;
    logic       code_upd = 1'b0;
    logic       locked;
    logic [9:0] q_locked;
    logic       lock_lost;
    logic       timeout;
    logic [7:0] lost_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_ext = ~clk_ext;

    fmdll_lock_detect #(
        .TOL(TOL), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNL), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_ext(clk_ext), .rst_n(rst_n), .M(M), .N(N), .Sel(Sel),
        .Q(Q), .code_upd(code_upd), .locked(locked), .q_locked(q_locked),
        .lock_lost(lock_lost), .timeout(timeout), .lost_cnt(lost_cnt)
    );

    // reference model: state 0=idle 1=acquire 2=locked
    int         st, prev, scnt, miss, wd, mr, nr;
    logic       e_locked, e_lost, e_to;
    logic [9:0] e_qlk;
    logic [7:0] e_lcnt;

    always @(posedge clk_ext) begin : model
        int d;
        bit lost;
        lost = 1'b0;
        e_to = 1'b0;
        if (!rst_n) begin
            st = 0; prev = 0; scnt = 0; miss = 0; wd = 0;
            mr = int'(M); nr = int'(N);
            e_qlk = '0; e_lcnt = '0;
        end else begin
            d = int'(Q) - prev;
            if (d < 0) d = -d;
            if (Sel == 2'b10) begin
                lost = (st == 2);
                st = 0; scnt = 0; miss = 0; wd = 0;
            end else if (int'(M) != mr || int'(N) != nr) begin
                lost = (st == 2);
                if (st != 0) st = 1;
                scnt = 0; miss = 0; wd = 0;
            end else if (st != 0 && wd == TO - 1 && !code_upd) begin
                lost = (st == 2);
                e_to = 1'b1;
                st = 0; scnt = 0; miss = 0; wd = 0;
            end else begin
                wd = (st == 0 || code_upd) ? 0 : wd + 1;
                if (code_upd) begin
                    if (st == 0) begin
                        st = 1; scnt = 0;
                    end else if (st == 1) begin
                        scnt = (d <= TOL) ? scnt + 1 : 0;
                        if (scnt == LOCK) begin
                            st = 2; e_qlk = Q; scnt = 0; miss = 0;
                        end
                    end else begin
                        miss = (d <= TOL) ? 0 : miss + 1;
                        if (miss == UNL) begin
                            st = 1; scnt = 0; miss = 0; lost = 1'b1;
                        end
                    end
                    prev = int'(Q);
                end
            end
            mr = int'(M); nr = int'(N);
            if (lost && e_lcnt != 8'hFF) e_lcnt = e_lcnt + 8'd1;
        end
        e_lost   = lost;
        e_locked = (st == 2);
    end

    logic [20:0] act, expv;
    assign act  = {locked, q_locked, lock_lost, timeout, lost_cnt};
    assign expv = {e_locked, e_qlk, e_lost, e_to, e_lcnt};

    task automatic tick();
        @(negedge clk_ext);
    endtask

    task automatic strobe(input int q);
        Q = 10'(q);
        code_upd = 1'b1;
        @(negedge clk_ext);
        code_upd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        Sel = 2'b01; M = 2'd1; N = 4'd4;
        tick(); tick();
        n_cmp++;
        if (act !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", act);
        end
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL reset_model: got %h want %h", act, expv);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lock_basic();
        int qs[9] = '{300, 301, 300, 302, 301, 300, 301, 302, 301};
        for (int i = 0; i < 9; i++) begin
            strobe(qs[i]);
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL lock_basic[%0d]: got %h want %h", i, act, expv);
            end
            if (i == 7) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_bad++;
                    $display("FAIL lock_early: got %b want 0", locked);
                end
            end
            if (i < 8) repeat ($urandom_range(0, 2)) tick();
        end
        n_cmp++;
        if (locked !== 1'b1 || q_locked !== 10'd301) begin
            n_bad++;
            $display("FAIL lock_basic_end: got %b/%0d want 1/301",
                     locked, q_locked);
        end
    endtask

    task automatic test_glitch();
        int qs[14] = '{300, 300, 300, 300, 300, 310,
                       300, 300, 300, 300, 300, 300, 300, 300};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            strobe(qs[i]);
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL glitch[%0d]: got %h want %h", i, act, expv);
            end
            if (i == 5) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_bad++;
                    $display("FAIL glitch_lock: got %b want 0", locked);
                end
            end
        end
        strobe(300);
        n_cmp++;
        if (locked !== 1'b1 || q_locked !== 10'd300 || act !== expv) begin
            n_bad++;
            $display("FAIL glitch_end: got %h want %h", act, expv);
        end
    endtask

    task automatic test_unlock();
        int qs[5] = '{320, 300, 320, 330, 340};
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            strobe(qs[i]);
            if (lock_lost) pulses++;
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL unlock[%0d]: got %h want %h", i, act, expv);
            end
        end
        n_cmp++;
        if (pulses != 1 || locked !== 1'b0 || lost_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL unlock_end: got %0d/%b/%0d want 1/0/1",
                     pulses, locked, lost_cnt);
        end
    endtask

    task automatic test_timeout();
        int to_n = 0, lost_n = 0, to_at = -1;
        for (int i = 0; i < 8; i++) strobe(340);
        n_cmp++;
        if (locked !== 1'b1 || act !== expv) begin
            n_bad++;
            $display("FAIL timeout_relock: got %h want %h", act, expv);
        end
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (timeout) begin to_n++; to_at = i; end
            if (lock_lost) lost_n++;
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL timeout[%0d]: got %h want %h", i, act, expv);
            end
        end
        n_cmp++;
        if (to_n != 1 || to_at != TO || lost_n != 1) begin
            n_bad++;
            $display("FAIL timeout_pulses: got %0d@%0d/%0d want 1@%0d/1",
                     to_n, to_at, lost_n, TO);
        end
        n_cmp++;
        if (q_locked !== 10'd340 || locked !== 1'b0 || lost_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL timeout_hold: got %0d/%b/%0d want 340/0/2",
                     q_locked, locked, lost_cnt);
        end
    endtask

    task automatic test_mn_change();
        for (int i = 0; i < 9; i++) strobe(500);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL mn_lock: got %b want 1", locked);
        end
        N = 4'd5;
        strobe(900);
        n_cmp++;
        if (locked !== 1'b0 || lock_lost !== 1'b1 || act !== expv) begin
            n_bad++;
            $display("FAIL mn_change: got %h want %h", act, expv);
        end
        strobe(501);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL mn_ignored: got %h want %h", act, expv);
        end
        Sel = 2'b10;
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || lock_lost !== 1'b0 || act !== expv) begin
            n_bad++;
            $display("FAIL sel_idle: got %h want %h", act, expv);
        end
        strobe(502);
        n_cmp++;
        if (locked !== 1'b0 || act !== expv) begin
            n_bad++;
            $display("FAIL sel_hold: got %h want %h", act, expv);
        end
        Sel = 2'b01;
        tick();
    endtask

    task automatic test_random();
        int qw = 512;
        for (int i = 0; i < 2000; i++) begin
            Sel = ($urandom_range(0, 199) == 0) ? 2'b10 : 2'($urandom_range(0, 1) ? 1 : 3);
            if ($urandom_range(0, 299) == 0) N = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) M = 2'($urandom_range(0, 3));
            code_upd = ($urandom_range(0, 2) == 0);
            if (code_upd) begin
                qw += ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 6) - 3;
                if (qw < 100 || qw > 900) qw = 512;
                Q = 10'(qw);
            end
            tick();
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h want %h", i, act, expv);
            end
        end
        code_upd = 1'b0;
        Sel = 2'b01;
        tick();
    endtask

    task automatic test_saturate();
        Sel = 2'b10;
        tick();
        Sel = 2'b01;
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < 9; i++) strobe(100);
            Sel = 2'b10;
            tick();
            Sel = 2'b01;
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL saturate[%0d]: got %h want %h", k, act, expv);
            end
        end
        n_cmp++;
        if (lost_cnt !== 8'hFF) begin
            n_bad++;
            $display("FAIL saturate_end: got %h want ff", lost_cnt);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) strobe(700);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_lock: got %b want 1", locked);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (act !== 21'd0 || act !== expv) begin
            n_bad++;
            $display("FAIL mid_reset: got %h want 0", act);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (act !== 21'd0) begin
            n_bad++;
            $display("FAIL post_reset: got %h want 0", act);
        end
    endtask

    initial begin
        test_reset();
        test_lock_basic();
        test_glitch();
        test_unlock();
        test_timeout();
        test_mn_change();
        test_random();
        test_saturate();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
